// File: rtl/capture_fifo.sv
// Capture buffer: a burst-capture FSM fills an on-chip FIFO that the FW load
// controller drains with a one-cycle read latency.
module capture_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_SIZE  = 1024,
  localparam int CNT_WIDTH = $clog2(FIFO_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_vld,
  input  logic                  cap_start,
  input  logic [CNT_WIDTH-1:0]  cap_len,
  output logic                  cap_busy,
  output logic                  cap_done,
  input  logic                  rd_req,
  output logic                  rd_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_WIDTH-1:0]  fill_level,
  output logic                  event_overflow,
  output logic                  event_underflow
);
  localparam int PTR_WIDTH = $clog2(FIFO_SIZE);
  localparam logic [CNT_WIDTH-1:0] FULL_LEVEL = CNT_WIDTH'(FIFO_SIZE);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  cap_cnt;
  logic [CNT_WIDTH-1:0]  cap_len_q;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  last_push;

  assign rd_rdy   = (fill_level != '0);
  assign cap_busy = (state != IDLE);
  assign full     = (fill_level == FULL_LEVEL);
  assign pop      = rd_req & rd_rdy;
  // When full, a same-cycle pop frees exactly the slot being written (wr_ptr == rd_ptr).
  assign push      = (state == CAPTURE) & sample_vld & (~full | pop);
  assign last_push = push & ((cap_cnt + CNT_ONE) == cap_len_q);

  // NOTE: storage is kept out of reset so it can map onto RAM; emptying the pointers
  // on reset already makes any stale words unreachable.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= sample_in;
  end

  // NOTE: every update below is non-blocking, so all branches see the pre-edge
  // push/pop/fill_level values and the block behaves as one set of flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill_level      <= '0;
      cap_cnt         <= '0;
      cap_len_q       <= '0;
      rd_data         <= '0;
      cap_done        <= 1'b0;
      event_overflow  <= 1'b0;
      event_underflow <= 1'b0;
    end else begin
      cap_done        <= last_push;
      event_overflow  <= (state == CAPTURE) & sample_vld & full & ~pop;
      event_underflow <= rd_req & ~rd_rdy;

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_data <= mem[rd_ptr];
      end

      case ({push, pop})
        2'b10:   fill_level <= fill_level + CNT_ONE;
        2'b01:   fill_level <= fill_level - CNT_ONE;
        default: fill_level <= fill_level;
      endcase

      case (state)
        IDLE: begin
          if (cap_start && cap_len != '0) begin
            cap_len_q <= cap_len;
            cap_cnt   <= '0;
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (push) begin
            cap_cnt <= cap_cnt + CNT_ONE;
            if (last_push) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fill_level == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_fifo.sv
// Randomised scoreboard bench for capture_fifo: a queue-based reference model predicts
// every output each cycle and read data is checked through an expected-word queue.
module tb_capture_fifo;
  localparam int DW = 32;
  localparam int FS = 8;
  localparam int CW = $clog2(FS) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] sample_in;
  logic          sample_vld;
  logic          cap_start;
  logic [CW-1:0] cap_len;
  logic          cap_busy;
  logic          cap_done;
  logic          rd_req;
  logic          rd_rdy;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] fill_level;
  logic          event_overflow;
  logic          event_underflow;

  always #5 clk = ~clk;

  capture_fifo #(.DATA_WIDTH(DW), .FIFO_SIZE(FS)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_vld(sample_vld),
    .cap_start(cap_start), .cap_len(cap_len), .cap_busy(cap_busy), .cap_done(cap_done),
    .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_data(rd_data), .fill_level(fill_level),
    .event_overflow(event_overflow), .event_underflow(event_underflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue, capture is "accepting until len words".
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_rd_q[$];
  bit            m_capturing = 0;
  bit            m_draining  = 0;
  int            m_len = 0;
  int            m_got = 0;
  int            m_resets = 0;
  bit            e_done = 0, e_over = 0, e_under = 0, rd_pending = 0, mon_en = 0;

  always @(posedge clk) begin : model
    bit pop_m;
    bit push_m;
    if (rst) begin
      m_q.delete();
      exp_rd_q.delete();
      m_capturing = 0;
      m_draining  = 0;
      m_got       = 0;
      e_done      = 0;
      e_over      = 0;
      e_under     = 0;
      rd_pending  = 0;
      m_resets++;
      mon_en      = 1;
    end else begin
      pop_m   = rd_req && (m_q.size() != 0);
      push_m  = m_capturing && sample_vld && ((m_q.size() < FS) || pop_m);
      e_under = rd_req && (m_q.size() == 0);
      e_over  = m_capturing && sample_vld && !push_m;
      e_done  = 0;
      rd_pending = pop_m;
      if (m_draining && m_q.size() == 0) m_draining = 0;
      else if (!m_capturing && !m_draining && cap_start && cap_len != 0) begin
        m_capturing = 1;
        m_len = int'(cap_len);
        m_got = 0;
      end
      if (pop_m) exp_rd_q.push_back(m_q.pop_front());
      if (push_m) begin
        m_q.push_back(sample_in);
        m_got++;
        if (m_got == m_len) begin
          e_done = 1;
          m_capturing = 0;
          m_draining = 1;
        end
      end
    end
  end

  // Monitor: compares every output once per cycle, popping read data when a pop was issued.
  logic [DW-1:0] hold_rd = '0;
  int            seen_resets = 0;
  int            done_seen = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (seen_resets != m_resets) begin
        hold_rd = '0;
        seen_resets = m_resets;
      end
      if (rd_pending) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_scoreboard: read presented with no expected word queued");
        end else begin
          hold_rd = exp_rd_q.pop_front();
        end
      end
      check("rd_data", rd_data, hold_rd);
      check("fill_level", fill_level, m_q.size());
      check("rd_rdy", rd_rdy, m_q.size() != 0);
      check("cap_busy", cap_busy, m_capturing || m_draining);
      check("cap_done", cap_done, e_done);
      check("event_overflow", event_overflow, e_over);
      check("event_underflow", event_underflow, e_under);
      if (cap_done) done_seen++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_in();
    sample_vld = 1'b0;
    rd_req     = 1'b0;
    cap_start  = 1'b0;
  endtask

  task automatic start(input int len);
    cap_start = 1'b1;
    cap_len   = CW'(len);
    step();
    cap_start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (m_q.size() != 0 && guard < 4 * FS) begin
      rd_req = 1'b1;
      step();
      guard++;
    end
    clear_in();
    step();
    check("drain_bounded", guard < 4 * FS, 1);
  endtask

  task automatic random_burst(input int len);
    int sent;
    int cyc;
    int d0;
    sent = 0;
    cyc  = 0;
    d0   = done_seen;
    start(len);
    while ((sent < len || m_q.size() != 0 || m_capturing || m_draining) && cyc < 400) begin
      sample_vld = (sent < len) && ($urandom_range(0, 1) == 1) && (m_q.size() < FS);
      sample_in  = $urandom();
      rd_req     = ($urandom_range(0, 2) != 0);
      if (sample_vld) sent++;
      step();
      cyc++;
    end
    clear_in();
    step();
    step();
    check("burst_timeout", cyc < 400, 1);
    check("burst_done_once", done_seen - d0, 1);
    check("burst_idle", cap_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_in();
    sample_in = '0;
    cap_len   = '0;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_fill", fill_level, 0);
    check("reset_busy", cap_busy, 0);
    check("reset_rd_data", rd_data, 0);

    // T1: four-word burst, then four reads with one-cycle latency.
    start(4);
    for (int i = 0; i < 4; i++) begin
      sample_vld = 1'b1;
      sample_in  = DW'(32'hA0 + i);
      step();
      check("t1_fill", fill_level, i + 1);
    end
    clear_in();
    check("t1_done", cap_done, 1);
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      step();
      check("t1_rd_data", rd_data, 32'hA0 + i);
    end
    clear_in();
    check("t1_still_drain", cap_busy, 1);
    step();
    check("t1_idle", cap_busy, 0);

    // T3: read on empty FIFO.
    rd_req = 1'b1;
    step();
    clear_in();
    check("t3_underflow", event_underflow, 1);
    check("t3_rd_hold", rd_data, 32'hA3);
    check("t3_fill", fill_level, 0);
    step();
    check("t3_underflow_pulse", event_underflow, 0);

    // T2: overflow at full, then accepted push with simultaneous pop.
    start(10);
    for (int i = 0; i < FS; i++) begin
      sample_vld = 1'b1;
      sample_in  = $urandom();
      step();
    end
    check("t2_full", fill_level, FS);
    for (int i = 0; i < 2; i++) begin
      sample_in = $urandom();
      step();
      check("t2_overflow", event_overflow, 1);
      check("t2_fill_held", fill_level, FS);
      check("t2_capturing", cap_busy, 1);
    end
    rd_req    = 1'b1;
    sample_in = $urandom();
    step();
    check("t2_push_pop_fill", fill_level, FS);
    check("t2_push_pop_no_ovf", event_overflow, 0);
    sample_in = $urandom();
    step();
    check("t2_done_at_10", cap_done, 1);
    clear_in();
    drain();

    // T5: reset in the middle of a burst.
    start(8);
    for (int i = 0; i < 3; i++) begin
      sample_vld = 1'b1;
      sample_in  = $urandom();
      step();
    end
    sample_vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_fill", fill_level, 0);
    check("t5_rd_rdy", rd_rdy, 0);
    check("t5_busy", cap_busy, 0);
    check("t5_no_done", cap_done, 0);
    step();
    check("t5_no_done_later", cap_done, 0);

    // T6: ignored starts and idle samples.
    start(0);
    check("t6_zero_len", cap_busy, 0);
    start(3);
    check("t6_started", cap_busy, 1);
    sample_vld = 1'b1;
    sample_in  = $urandom();
    step();
    cap_start = 1'b1;
    cap_len   = CW'(6);
    sample_in = $urandom();
    step();
    cap_start = 1'b0;
    sample_in = $urandom();
    step();
    check("t6_len_kept", cap_done, 1);
    clear_in();
    drain();
    for (int i = 0; i < 3; i++) begin
      sample_vld = 1'b1;
      sample_in  = $urandom();
      step();
    end
    clear_in();
    check("t6_idle_samples", fill_level, 0);
    check("t6_idle_no_ovf", event_overflow, 0);

    // T4: randomised interleaving; cap_len is CW bits, so 20 words go as 15 + 5.
    random_burst(15);
    random_burst(5);
    for (int k = 0; k < 4; k++) random_burst($urandom_range(1, 15));

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
